// File: rtl/upscale_seq_ctrl.sv
// rtl/upscale_seq_ctrl.sv - row-buffered 3x horizontal/vertical replication sequencer
module upscale_seq_ctrl #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 72,
  parameter int SCALE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] s_pixel,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] m_pixel,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [1:0] h_phase,
  output logic [1:0] v_phase,
  output logic       eol,
  output logic       eof,
  output logic       busy,
  output logic       done
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [1:0]    P_LAST = 2'(SCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_REPLAY = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [7:0]    row_q [IMG_W];
  logic [XW-1:0] x_in_q;
  logic [XW-1:0] x_out_q;
  logic [1:0]    h_cnt_q;
  logic [1:0]    v_cnt_q;
  logic [YW-1:0] y_q;
  // Set once the final beat of the frame is in the output register; replay
  // stops issuing and waits for that beat to be accepted.
  logic          fin_q;

  logic [7:0]    m_pixel_q;
  logic          m_valid_q;
  logic [1:0]    h_phase_q;
  logic [1:0]    v_phase_q;
  logic          eol_q;
  logic          eof_q;
  logic          busy_q;
  logic          done_q;

  logic in_fire;
  logic issue;
  logic accept;
  logic finish;
  logic trip_last;
  logic row_last;
  logic beat_eol;
  logic beat_eof;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: load a row, replay it, then load the next or finish
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (in_fire && (x_in_q == X_LAST)) state_d = S_REPLAY;
      end
      S_REPLAY: begin
        if (issue && trip_last && !row_last) begin
          state_d = S_LOAD;
        end else if (finish) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output/control decode from the current state and counters
  always_comb begin
    s_ready   = 1'b0;
    in_fire   = 1'b0;
    issue     = 1'b0;
    accept    = m_valid_q && m_ready;
    finish    = 1'b0;
    trip_last = (h_cnt_q == P_LAST) && (x_out_q == X_LAST) && (v_cnt_q == P_LAST);
    row_last  = (y_q == Y_LAST);
    beat_eol  = (h_cnt_q == P_LAST) && (x_out_q == X_LAST);
    beat_eof  = beat_eol && (v_cnt_q == P_LAST) && row_last;
    case (state_q)
      S_LOAD: begin
        s_ready = 1'b1;
        in_fire = s_valid;
      end
      S_REPLAY: begin
        issue  = !fin_q && (!m_valid_q || m_ready);
        finish = fin_q && accept;
      end
      default: begin
        s_ready = 1'b0;
      end
    endcase
  end

  // Row buffer write; contents need no reset since every entry is written before replay
  always_ff @(posedge clk) begin
    if (in_fire) row_q[x_in_q] <= s_pixel;
  end

  // Position counters: input column, replay phase/column/pass and row index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_in_q  <= '0;
      x_out_q <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      y_q     <= '0;
      fin_q   <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        x_in_q  <= '0;
        x_out_q <= '0;
        h_cnt_q <= '0;
        v_cnt_q <= '0;
        y_q     <= '0;
        fin_q   <= 1'b0;
      end
      if (in_fire) begin
        x_in_q <= (x_in_q == X_LAST) ? '0 : x_in_q + 1'b1;
      end
      if (issue) begin
        if (h_cnt_q == P_LAST) begin
          h_cnt_q <= '0;
          if (x_out_q == X_LAST) begin
            x_out_q <= '0;
            v_cnt_q <= (v_cnt_q == P_LAST) ? 2'd0 : v_cnt_q + 2'd1;
          end else begin
            x_out_q <= x_out_q + 1'b1;
          end
        end else begin
          h_cnt_q <= h_cnt_q + 2'd1;
        end
        if (trip_last) begin
          if (row_last) fin_q <= 1'b1;
          else          y_q   <= y_q + 1'b1;
        end
      end
      if (finish) fin_q <= 1'b0;
    end
  end

  // Output beat register plus frame busy/done flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pixel_q <= '0;
      m_valid_q <= 1'b0;
      h_phase_q <= '0;
      v_phase_q <= '0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if ((state_q == S_IDLE) && start) busy_q <= 1'b1;
      if (issue) begin
        m_valid_q <= 1'b1;
        m_pixel_q <= row_q[x_out_q];
        h_phase_q <= h_cnt_q;
        v_phase_q <= v_cnt_q;
        eol_q     <= beat_eol;
        eof_q     <= beat_eof;
      end else if (accept) begin
        m_valid_q <= 1'b0;
      end
      if (finish) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign m_pixel = m_pixel_q;
  assign m_valid = m_valid_q;
  assign h_phase = h_phase_q;
  assign v_phase = v_phase_q;
  assign eol     = eol_q;
  assign eof     = eof_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_upscale_seq_ctrl.sv
// tb/tb_upscale_seq_ctrl.sv - randomized self-checking bench for upscale_seq_ctrl
module tb_upscale_seq_ctrl;
  localparam int W   = 4;
  localparam int H   = 2;
  localparam int NB  = 9 * W * H;
  localparam int BW  = 128;
  localparam int BH  = 72;
  localparam int BNB = 9 * BW * BH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, s_valid, m_ready;
  logic [7:0] s_pixel;
  logic       s_ready, m_valid, eol, eof, busy, done;
  logic [7:0] m_pixel;
  logic [1:0] h_phase, v_phase;

  logic       b_rst, b_start, b_s_valid, b_m_ready;
  logic [7:0] b_s_pixel;
  logic       b_s_ready, b_m_valid, b_eol, b_eof, b_busy, b_done;
  logic [7:0] b_m_pixel;
  logic [1:0] b_h_phase, b_v_phase;

  upscale_seq_ctrl #(.IMG_W(W), .IMG_H(H), .SCALE(3)) dut (
    .clk(clk), .rst(rst), .start(start), .s_pixel(s_pixel), .s_valid(s_valid),
    .s_ready(s_ready), .m_pixel(m_pixel), .m_valid(m_valid), .m_ready(m_ready),
    .h_phase(h_phase), .v_phase(v_phase), .eol(eol), .eof(eof), .busy(busy), .done(done)
  );

  upscale_seq_ctrl dut_big (
    .clk(clk), .rst(b_rst), .start(b_start), .s_pixel(b_s_pixel), .s_valid(b_s_valid),
    .s_ready(b_s_ready), .m_pixel(b_m_pixel), .m_valid(b_m_valid), .m_ready(b_m_ready),
    .h_phase(b_h_phase), .v_phase(b_v_phase), .eol(b_eol), .eof(b_eof), .busy(b_busy), .done(b_done)
  );

  int checks = 0;
  int errors = 0;
  bit big_done = 0;
  int img [W*H];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Beat n of a frame maps to (row, pass, column, phase) by plain division
  task automatic coords(input int n, input int w, output int y, output int v, output int x, output int h);
    h = n % 3;
    x = (n / 3) % w;
    v = (n / (3 * w)) % 3;
    y = n / (9 * w);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_pixel"}, m_pixel, 0);
    check({tag, "_h_phase"}, h_phase, 0);
    check({tag, "_v_phase"}, v_phase, 0);
    check({tag, "_eol"}, eol, 0);
    check({tag, "_eof"}, eof, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_s_ready"}, s_ready, 0);
  endtask

  task automatic run_frame(input bit ramp, input bit gaps, input bit bp, input bit noise, input int abort_at);
    int n, in_n, eols, eofs, dones, cyc, eof_cyc, after, y, v, x, h, r;
    bit hold, e_eol, e_eof;
    logic [7:0] sp;
    logic [1:0] sh, sv;
    logic se, sf;
    n = 0; in_n = 0; eols = 0; eofs = 0; dones = 0; cyc = 0; eof_cyc = -10; after = 0;
    hold = 0; sp = '0; sh = '0; sv = '0; se = 0; sf = 0;
    for (int i = 0; i < W * H; i++) img[i] = ramp ? i : int'($urandom_range(0, 255));
    @(negedge clk);
    start = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("s_ready_after_start", s_ready, 1);
    while (cyc < 3000 && !(dones > 0 && after >= 1)) begin
      if (dones > 0) after++;
      s_valid = (in_n < W * H) && (!gaps || (cyc % 2 == 1));
      s_pixel = (in_n < W * H) ? 8'(img[in_n]) : 8'd0;
      m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      start   = noise && ((in_n == W + 1) || (n == 12));
      if (abort_at >= 0 && n >= abort_at) begin
        rst = 1'b1;
        #1;
        check_idle_outputs("abort");
        @(negedge clk);
        rst = 1'b0; start = 1'b0; s_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("abort_no_done", done, 0);
        end
        return;
      end
      if (hold) begin
        check("hold_valid", m_valid, 1);
        check("hold_pixel", m_pixel, sp);
        check("hold_h", h_phase, sh);
        check("hold_v", v_phase, sv);
        check("hold_eol", eol, se);
        check("hold_eof", eof, sf);
      end
      hold = m_valid && !m_ready;
      sp = m_pixel; sh = h_phase; sv = v_phase; se = eol; sf = eof;
      if (m_valid && m_ready) begin
        if (n < NB) begin
          coords(n, W, y, v, x, h);
          e_eol = (h == 2) && (x == W - 1);
          e_eof = e_eol && (v == 2) && (y == H - 1);
          check("pixel", m_pixel, img[y * W + x]);
          check("h_phase", h_phase, h);
          check("v_phase", v_phase, v);
          check("eol", eol, e_eol);
          check("eof", eof, e_eof);
        end else begin
          check("beat_overflow", n + 1, NB);
        end
        if (eof) eof_cyc = cyc;
        eols += int'(eol);
        eofs += int'(eof);
        n++;
      end
      if (s_valid && s_ready) begin
        r = in_n / W;
        if (r > 0) check("load_after_replay", (n >= 9 * W * r - 1), 1);
        in_n++;
      end
      if (done) begin
        dones++;
        check("done_timing", cyc - eof_cyc, 1);
        check("busy_with_done", busy, 0);
        check("m_valid_with_done", m_valid, 0);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; s_valid = 1'b0;
    if (abort_at >= 0) check("abort_reached", n, abort_at);
    check("done_one_cycle", done, 0);
    check("idle_s_ready", s_ready, 0);
    check("beat_count", n, NB);
    check("eol_count", eols, 3 * H);
    check("eof_count", eofs, 1);
    check("input_count", in_n, W * H);
    check("done_count", dones, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_pixel = '0; m_ready = 1'b0;
    #1;
    check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle");
    run_frame(1, 0, 0, 0, -1);
    run_frame(1, 0, 1, 0, -1);
    run_frame(0, 1, 0, 0, -1);
    run_frame(0, 0, 1, 0, 9 * W + 5);
    run_frame(1, 0, 0, 0, -1);
    run_frame(0, 1, 1, 1, -1);
    for (int g = 0; g < 100000 && !big_done; g++) @(negedge clk);
    check("big_finished", big_done, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int bn, bin, beols, beofs, bcyc, y, v, x, h;
    bit bfin;
    bn = 0; bin = 0; beols = 0; beofs = 0; bcyc = 0; bfin = 0;
    b_rst = 1'b1; b_start = 1'b0; b_s_valid = 1'b0; b_s_pixel = '0; b_m_ready = 1'b1;
    repeat (2) @(negedge clk);
    b_rst = 1'b0;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    while (bcyc < 96000 && !bfin) begin
      b_s_valid = (bin < BW * BH);
      b_s_pixel = 8'(bin % 256);
      if (b_m_valid && b_m_ready) begin
        coords(bn, BW, y, v, x, h);
        check("big_pixel", b_m_pixel, (y * BW + x) % 256);
        check("big_h_phase", b_h_phase, h);
        check("big_v_phase", b_v_phase, v);
        beols += int'(b_eol);
        beofs += int'(b_eof);
        bn++;
      end
      if (b_s_valid && b_s_ready) bin++;
      if (b_done) bfin = 1;
      @(negedge clk);
      bcyc++;
    end
    b_s_valid = 1'b0;
    check("big_done_seen", bfin, 1);
    check("big_beat_count", bn, BNB);
    check("big_eol_count", beols, 3 * BH);
    check("big_eof_count", beofs, 1);
    check("big_input_count", bin, BW * BH);
    big_done = 1;
  end

endmodule

// File: doc/upscale_seq_ctrl.md
# upscale_seq_ctrl

Frame sequencer that sits between the pixel source and the 3x bicubic upscaler. It accepts one input row at a time over a valid/ready stream and holds it in an internal row buffer. It then replays that row as a 3x-expanded stream: each pixel 3 times horizontally, the whole row 3 times vertically. Each beat is tagged with its horizontal/vertical phase, which replaces the testbench-driven replication and phase generation currently feeding the upscaler.

## Interface
- IMG_W, 128, input pixels per row (2..1024)
- IMG_H, 72, input rows per frame (1..1024)
- SCALE, 3, replication factor; fixed at 3 (phases 0..2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- s_pixel  in  8  input pixel
- s_valid  in  1  input pixel valid
- s_ready  out  1  block accepts s_pixel; high only in LOAD
- m_pixel  out  8  replicated pixel, to upscaler pixel_in
- m_valid  out  1  beat valid, to upscaler input_valid
- m_ready  in  1  downstream accepts beat
- h_phase  out  2  horizontal phase of current beat (0..2)
- v_phase  out  2  vertical phase of current beat (0..2)
- eol  out  1  high with the last beat of each output row
- eof  out  1  high with the last beat of the frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame completion

## Operation
- States: IDLE, LOAD, REPLAY.
- IDLE: if start, clear all counters and go to LOAD.
- LOAD: s_ready=1. Each s_valid&&s_ready writes buf[x_in]; x_in increments. The beat with x_in=IMG_W-1 moves the state to REPLAY, and x_in resets to 0.
- REPLAY: issue beats in this nested order:
  - h_cnt 0..2 (innermost)
  - x_out 0..IMG_W-1
  - v_cnt 0..2
- A beat is issued when the output register is empty or being accepted (!m_valid || m_ready). The issued beat is registered into m_pixel=buf[x_out], h_phase=h_cnt, v_phase=v_cnt, eol, eof.
- Row buffer: IMG_W x 8 register array. Write in LOAD, combinational read in REPLAY.
- Last beat of a row triplet (h_cnt=2, x_out=IMG_W-1, v_cnt=2): y increments, then:
  - y<IMG_H-1: go to LOAD for the next row.
  - y=IMG_H-1: go to IDLE after that beat's handshake completes.
- The output register may still hold an unaccepted beat while LOAD overwrites buf. This is legal because the beat is already captured.
- eol=1 iff h_cnt=2 and x_out=IMG_W-1.
- eof=1 iff eol and v_cnt=2 and y=IMG_H-1.
- done pulses for one cycle after the eof beat is accepted. busy falls in the same cycle.
- start outside IDLE is ignored. s_valid outside LOAD is ignored (s_ready=0).
- Counter widths are $clog2 of their ranges. No counter wraps except through the transitions above.
- Reset values: state=IDLE; all counters 0; s_ready=0, m_valid=0, m_pixel=0, h_phase=0, v_phase=0, eol=0, eof=0, busy=0, done=0.
- Asserting rst mid-frame aborts immediately, with no done pulse. The buffer contents are don't-care.

## Timing
- start sampled at edge E0: busy=1 and s_ready=1 from E0.
- The edge accepting the IMG_W-th input pixel enters REPLAY. m_valid rises at the following edge.
- With m_ready held high, a row triplet occupies 9*IMG_W consecutive m_valid cycles with no bubbles.
- Between triplets, s_ready=1 for at least IMG_W cycles. m_valid drops after the final beat drains and stays low until the next REPLAY.
- Backpressure: while m_valid && !m_ready, m_pixel, h_phase, v_phase, eol and eof hold stable and counters freeze.
- Per frame: exactly 9*IMG_W*IMG_H accepted beats, IMG_W*IMG_H accepted input pixels, 3*IMG_H eol beats and 1 eof beat.
- done is registered: it rises the edge after the eof handshake edge.

## Test plan
- **Ramp frame:** IMG_W=4, IMG_H=2, input 0..7, m_ready=1.
  - Row 0 output: 0,0,0,1,1,1,2,2,2,3,3,3 repeated 3 times, with h_phase cycling 0,1,2 and v_phase 0,1,2 per repeat.
  - eol on beats 12, 24 and 36; eof on beat 72 only.
  - done one cycle later.
- **Backpressure:** same frame with m_ready toggling pseudo-randomly.
  - Output sequence is identical to the ramp frame.
  - m_pixel/phases are stable whenever m_valid && !m_ready.
  - Exactly 72 beats.
- **Input gaps:** s_valid low every other cycle.
  - Buffer contents are correct and output is unchanged.
  - s_ready=0 throughout REPLAY.
- **Reset mid-frame:** assert rst during row 1 REPLAY.
  - All outputs return to reset values asynchronously, with no done pulse.
  - A new start produces a complete, correct frame.
- **start while busy:** pulse start during LOAD and during REPLAY.
  - The frame is unaffected; exactly one done pulse.
- **Default parameters, 128x72 ramp mod 256:** beat count 82944, eol count 216, eof count 1.
